// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP training sequencer: Q8.8 type, fixed-point
// constants and the sequencer state encoding.
package mlp_pkg;

   typedef logic signed [15:0] q8_8_t;

   localparam logic [15:0] ONE  = 16'h0100;
   localparam logic [15:0] HALF = 16'h0080;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TRAIN   = 3'd1,
      SETTLE  = 3'd2,
      TEST    = 3'd3,
      CAPTURE = 3'd4
   } state_e;

endpackage

// File: rtl/mlp_sample_mem.sv
// Training sample storage: DEPTH entries of {x1, x2, y}, one synchronous
// write port and one combinational read port.
module mlp_sample_mem #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 48,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: storage has no reset; entries are only read after being written,
   // and leaving it unreset lets synthesis map it onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/mlp_train_sequencer.sv
// Streams the stored sample set to a downstream MLP for a number of epochs,
// then applies one test vector and captures the network's response.
module mlp_train_sequencer
   import mlp_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int DW    = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [DW-1:0] load_x1,
   input  logic [DW-1:0] load_x2,
   input  logic [DW-1:0] load_y,
   input  logic          start,
   input  logic [15:0]   epochs,
   input  logic [DW-1:0] test_x1,
   input  logic [DW-1:0] test_x2,
   output logic          train,
   output logic [DW-1:0] x1,
   output logic [DW-1:0] x2,
   output logic [DW-1:0] y_target,
   input  logic [DW-1:0] y_in,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] result,
   output logic          result_class,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
   localparam logic signed [DW-1:0] HALF_DW = DW'(HALF);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [15:0]   epoch_q, epoch_d;
   logic [15:0]   epochs_q, epochs_d;
   logic [DW-1:0] tx1_q, tx1_d;
   logic [DW-1:0] tx2_q, tx2_d;
   logic [DW-1:0] result_q, result_d;
   logic          class_q, class_d;

   logic            mem_we;
   logic [3*DW-1:0] mem_wdata;
   logic [3*DW-1:0] mem_rdata;
   logic [16:0]     epoch_inc;
   logic            last_idx;

   assign mem_wdata = {load_x1, load_x2, load_y};

   mlp_sample_mem #(
      .DEPTH (DEPTH),
      .WIDTH (3 * DW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (count_q[AW-1:0]),
      .wdata (mem_wdata),
      .raddr (idx_q),
      .rdata (mem_rdata)
   );

   // Epoch arithmetic is one bit wider so epochs=0xFFFF terminates cleanly.
   assign epoch_inc = {1'b0, epoch_q} + 17'd1;
   assign last_idx  = ({1'b0, idx_q} == (count_q - 1'b1));

   // NOTE: every output and _d signal gets a default before the case so no
   // path through the block leaves a value unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      epoch_d    = epoch_q;
      epochs_d   = epochs_q;
      tx1_d      = tx1_q;
      tx2_d      = tx2_q;
      result_d   = result_q;
      class_d    = class_q;
      mem_we     = 1'b0;
      load_ready = (state_q == IDLE) && (count_q < DEPTH_C);
      train      = 1'b0;
      x1         = '0;
      x2         = '0;
      y_target   = '0;
      busy       = (state_q != IDLE);
      done       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // clear beats load, and any load request suppresses start.
            if (clear) begin
               count_d = '0;
            end else if (load_valid) begin
               if (load_ready) begin
                  mem_we  = 1'b1;
                  count_d = count_q + 1'b1;
               end
            end else if (start) begin
               epochs_d = epochs;
               tx1_d    = test_x1;
               tx2_d    = test_x2;
               idx_d    = '0;
               epoch_d  = '0;
               if ((count_q != '0) && (epochs != 16'd0)) begin
                  state_d = TRAIN;
               end else begin
                  state_d = SETTLE;
               end
            end
         end

         TRAIN: begin
            train    = 1'b1;
            x1       = mem_rdata[3*DW-1:2*DW];
            x2       = mem_rdata[2*DW-1:DW];
            y_target = mem_rdata[DW-1:0];
            if (last_idx) begin
               idx_d   = '0;
               epoch_d = epoch_inc[15:0];
               if (epoch_inc == {1'b0, epochs_q}) begin
                  epoch_d = '0;
                  state_d = SETTLE;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         SETTLE: begin
            state_d = TEST;
         end

         TEST: begin
            x1       = tx1_q;
            x2       = tx2_q;
            result_d = y_in;
            class_d  = ($signed(y_in) > HALF_DW);
            state_d  = CAPTURE;
         end

         CAPTURE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         idx_q    <= '0;
         epoch_q  <= '0;
         epochs_q <= '0;
         tx1_q    <= '0;
         tx2_q    <= '0;
         result_q <= '0;
         class_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         epoch_q  <= epoch_d;
         epochs_q <= epochs_d;
         tx1_q    <= tx1_d;
         tx2_q    <= tx2_d;
         result_q <= result_d;
         class_q  <= class_d;
      end
   end

   assign count        = count_q;
   assign result       = result_q;
   assign result_class = class_q;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Scoreboard bench for mlp_train_sequencer: stimulus pushes expected training
// samples and run results; a monitor pops and compares as the DUT presents them.
module tb_mlp_train_sequencer;
   import mlp_pkg::*;

   localparam int DEPTH = 16;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [DW-1:0] load_x1 = '0, load_x2 = '0, load_y = '0;
   logic          start = 1'b0;
   logic [15:0]   epochs = '0;
   logic [DW-1:0] test_x1 = '0, test_x2 = '0;
   logic          train;
   logic [DW-1:0] x1, x2, y_target;
   logic [DW-1:0] y_in = '0;
   logic          busy, done;
   logic [DW-1:0] result;
   logic          result_class;
   logic [4:0]    count;

   mlp_train_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_x1      (load_x1),
      .load_x2      (load_x2),
      .load_y       (load_y),
      .start        (start),
      .epochs       (epochs),
      .test_x1      (test_x1),
      .test_x2      (test_x2),
      .train        (train),
      .x1           (x1),
      .x2           (x2),
      .y_target     (y_target),
      .y_in         (y_in),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .result_class (result_class),
      .count        (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x1;
      logic [15:0] x2;
      logic [15:0] y;
   } sample_t;

   typedef struct {
      logic [15:0] result;
      logic        cls;
      int          busy_len;
      int          train_len;
   } run_t;

   sample_t train_q[$];
   run_t    run_q[$];
   sample_t fill_s[DEPTH];
   int      n_chk = 0;
   int      n_err = 0;
   int      busy_cnt = 0;
   int      train_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: event occurred that no stimulus predicted", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic sample_t xor_sample(input int i);
      sample_t s;
      logic    a, b;
      a    = (i % 2) == 1;
      b    = ((i / 2) % 2) == 1;
      s.x1 = a ? ONE : 16'h0000;
      s.x2 = b ? ONE : 16'h0000;
      s.y  = (a ^ b) ? ONE : 16'h0000;
      return s;
   endfunction

   task automatic load_sample(input sample_t s);
      load_valid = 1'b1;
      load_x1    = s.x1;
      load_x2    = s.x2;
      load_y     = s.y;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic start_run(input logic [15:0] ep, input logic [15:0] t1, input logic [15:0] t2);
      start   = 1'b1;
      epochs  = ep;
      test_x1 = t1;
      test_x2 = t2;
      tick();
      start = 1'b0;
   endtask

   task automatic push_run(input logic [15:0] r, input logic c, input int bl, input int tl);
      run_t e;
      e.result    = r;
      e.cls       = c;
      e.busy_len  = bl;
      e.train_len = tl;
      run_q.push_back(e);
   endtask

   task automatic wait_run(input int budget);
      int n;
      n = 0;
      while ((run_q.size() != 0 || busy !== 1'b0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         $display("FAIL run_timeout: got %0d cycles waiting, required under %0d", n, budget);
         n_chk++;
         n_err++;
         run_q.delete();
         train_q.delete();
      end
   endtask

   initial begin
      fork
         begin : monitor
            sample_t s;
            run_t    r;
            forever begin
               @(negedge clk);
               if (train === 1'b1) begin
                  train_cnt++;
                  if (train_q.size() == 0) begin
                     fail("train_unexpected");
                  end else begin
                     s = train_q.pop_front();
                     check("train_x1", x1, s.x1);
                     check("train_x2", x2, s.x2);
                     check("train_y_target", y_target, s.y);
                  end
               end
               if (busy === 1'b1) busy_cnt++;
               if (done === 1'b1) begin
                  if (run_q.size() == 0) begin
                     fail("done_unexpected");
                  end else begin
                     r = run_q.pop_front();
                     check("run_result", result, r.result);
                     check("run_class", result_class, r.cls);
                     check("run_busy_cycles", busy_cnt, r.busy_len);
                     check("run_train_cycles", train_cnt, r.train_len);
                  end
               end
               if (busy !== 1'b1) begin
                  busy_cnt  = 0;
                  train_cnt = 0;
               end
            end
         end

         begin : stimulus
            // Reset state
            repeat (3) tick();
            check("rst_load_ready", load_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_train", train, 0);
            check("rst_x1", x1, 0);
            check("rst_x2", x2, 0);
            check("rst_y_target", y_target, 0);
            check("rst_result", result, 0);
            check("rst_class", result_class, 0);
            check("rst_count", count, 0);
            rst_n = 1'b1;
            tick();

            // XOR set, 30 epochs: 300 training cycles + 3 tail cycles
            for (int i = 0; i < 10; i++) load_sample(xor_sample(i));
            check("xor_count", count, 10);
            for (int k = 0; k < 300; k++) train_q.push_back(xor_sample(k % 10));
            y_in = 16'h0081;
            push_run(16'h0081, 1'b1, 303, 300);
            start_run(16'd30, ONE, 16'h0000);
            check("xor_busy", busy, 1);
            check("xor_train", train, 1);
            repeat (20) tick();
            start_run(16'd1, 16'h1234, 16'h5678);
            wait_run(1000);
            check("xor_train_left", train_q.size(), 0);

            // result holds while y_in moves
            y_in = 16'h7FFF;
            repeat (5) tick();
            check("hold_result", result, 16'h0081);
            check("hold_class", result_class, 1);

            // epochs=0: straight to SETTLE/TEST/CAPTURE, class boundary at HALF
            y_in = HALF;
            push_run(HALF, 1'b0, 3, 0);
            start_run(16'd0, ONE, ONE);
            check("ep0_settle_busy", busy, 1);
            check("ep0_settle_train", train, 0);
            check("ep0_settle_x1", x1, 0);
            check("ep0_settle_x2", x2, 0);
            tick();
            check("ep0_test_x1", x1, ONE);
            check("ep0_test_x2", x2, ONE);
            check("ep0_test_y_target", y_target, 0);
            check("ep0_test_train", train, 0);
            wait_run(20);

            // clear then count=0 run, negative response classifies as 0
            clear = 1'b1;
            tick();
            clear = 1'b0;
            check("clear_count", count, 0);
            y_in = 16'hFF00;
            push_run(16'hFF00, 1'b0, 3, 0);
            start_run(16'd5, 16'h0000, ONE);
            wait_run(20);

            // Fill buffer, 17th write ignored
            for (int i = 0; i < DEPTH; i++) begin
               fill_s[i].x1 = 16'(i * 3 + 1);
               fill_s[i].x2 = 16'(i * 5 + 2);
               fill_s[i].y  = 16'(i * 7 + 3);
               load_sample(fill_s[i]);
            end
            check("full_count", count, DEPTH);
            check("full_load_ready", load_ready, 0);
            load_sample('{x1: 16'hDEAD, x2: 16'hBEEF, y: 16'hCAFE});
            check("full_17th_count", count, DEPTH);
            for (int i = 0; i < DEPTH; i++) train_q.push_back(fill_s[i]);
            y_in = ONE;
            push_run(ONE, 1'b1, DEPTH + 3, DEPTH);
            start_run(16'd1, 16'h0000, 16'h0000);
            wait_run(100);

            // clear wins over load; load suppresses start
            clear      = 1'b1;
            load_valid = 1'b1;
            tick();
            clear      = 1'b0;
            load_valid = 1'b0;
            check("clear_vs_load_count", count, 0);
            start = 1'b1;
            epochs = 16'd1;
            load_sample(xor_sample(1));
            start = 1'b0;
            check("load_vs_start_count", count, 1);
            check("load_vs_start_busy", busy, 0);
            clear = 1'b1;
            tick();
            clear = 1'b0;

            // Reset in the middle of training: abort, no done pulse
            for (int i = 0; i < 10; i++) load_sample(xor_sample(i));
            for (int k = 0; k < 300; k++) train_q.push_back(xor_sample(k % 10));
            start_run(16'd30, ONE, ONE);
            repeat (50) tick();
            rst_n = 1'b0;
            tick();
            check("abort_train", train, 0);
            check("abort_busy", busy, 0);
            check("abort_count", count, 0);
            check("abort_done", done, 0);
            check("abort_result", result, 0);
            rst_n = 1'b1;
            train_q.delete();
            repeat (10) tick();
            check("abort_no_pending_run", run_q.size(), 0);
         end
      join_any
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
